// File: rtl/ramn_if.sv
// Bus bundle for the ramn word RAM: write data, address, strobes and read-side status.
// The master drives requests and the slave (the RAM) returns read data and busy.
interface ramn_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
);
  logic [WIDTH-1:0]      in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  load;
  logic                  clear;
  logic [WIDTH-1:0]      out;
  logic                  busy;

  modport master (
    output in, address, load, clear,
    input  out, busy
  );

  modport slave (
    input  in, address, load, clear,
    output out, busy
  );
endinterface

// File: rtl/ramn.sv
// Parametrised WIDTH x 2^ADDR_WIDTH RAM with combinational read, clocked write,
// and a one-word-per-cycle hardware clear sweep started by reset or a clear request.
module ramn #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic   clk,
  input  logic   reset,
  ramn_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [WIDTH-1:0]      mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The sweep cannot be restarted by clear; only reset rewinds ptr mid-sweep.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + ADDR_WIDTH'(1);
        if (&ptr) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_comb begin
    bus.busy = (state == CLEAR);
    bus.out  = (state == CLEAR) ? '0 : mem[bus.address];
  end

  // A clear request in IDLE takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (!bus.clear && bus.load) begin
        mem[bus.address] <= bus.in;
      end
    end
  end
endmodule

// File: tb/tb_ramn.sv
// Directed self-checking bench for ramn: default 16x8 instance plus an 8-bit x 32 corner instance.
module tb_ramn;
  logic clk;
  logic reset_a;
  logic reset_b;
  int   errors;
  int   checks;

  ramn_if #(.WIDTH(16), .ADDR_WIDTH(3)) bus_a ();
  ramn_if #(.WIDTH(8),  .ADDR_WIDTH(5)) bus_b ();

  ramn #(.WIDTH(16), .ADDR_WIDTH(3)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  ramn #(.WIDTH(8), .ADDR_WIDTH(5)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops on the selected instance; -1 if it never does.
  task automatic wait_idle(input bit sel_b, output int edges);
    edges = 0;
    while ((sel_b ? bus_b.busy : bus_a.busy) === 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
    if (edges >= 200) edges = -1;
  endtask

  task automatic test_reset;
    int edges;
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 1", bus_a.busy);
    end
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_out: got %h expected 0000", bus_a.out);
    end
    wait_idle(1'b0, edges);
    checks++;
    if (edges !== 8) begin
      errors++;
      $display("[TB] FAIL reset_sweep_len: got %0d expected 8", edges);
    end
    for (int a = 0; a < 8; a++) begin
      bus_a.address = 3'(a);
      #1;
      checks++;
      if (bus_a.out !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_zero[%0d]: got %h expected 0000", a, bus_a.out);
      end
    end
  endtask

  task automatic test_write_read;
    bus_a.address = 3'd5;
    bus_a.in      = 16'hBEEF;
    bus_a.load    = 1'b1;
    #1;
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL write_old_value: got %h expected 0000", bus_a.out);
    end
    tick();
    checks++;
    if (bus_a.out !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL write_next_cycle: got %h expected beef", bus_a.out);
    end
    bus_a.address = 3'd0;
    bus_a.in      = 16'h1234;
    tick();
    bus_a.load    = 1'b0;
    bus_a.in      = 16'h0000;
    bus_a.address = 3'd5;
    #1;
    checks++;
    if (bus_a.out !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL read_addr5: got %h expected beef", bus_a.out);
    end
    bus_a.address = 3'd0;
    #1;
    checks++;
    if (bus_a.out !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL read_addr0: got %h expected 1234", bus_a.out);
    end
    bus_a.address = 3'd4;
    #1;
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL read_addr4: got %h expected 0000", bus_a.out);
    end
  endtask

  task automatic test_ignored_writes;
    int k;
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear   = 1'b0;
    bus_a.load    = 1'b1;
    bus_a.address = 3'd3;
    bus_a.in      = 16'hFFFF;
    k = 0;
    while (bus_a.busy === 1'b1 && k < 50) begin
      checks++;
      if (bus_a.out !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL busy_out_addr3 cycle %0d: got %h expected 0000", k, bus_a.out);
      end
      bus_a.address = 3'd5;
      #1;
      checks++;
      if (bus_a.out !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL busy_out_addr5 cycle %0d: got %h expected 0000", k, bus_a.out);
      end
      bus_a.address = 3'd3;
      tick();
      k++;
    end
    bus_a.load = 1'b0;
    bus_a.in   = 16'h0000;
    #1;
    checks++;
    if (k !== 8) begin
      errors++;
      $display("[TB] FAIL clear_sweep_len: got %0d expected 8", k);
    end
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL ignored_write_addr3: got %h expected 0000", bus_a.out);
    end
    bus_a.address = 3'd5;
    #1;
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL swept_addr5: got %h expected 0000", bus_a.out);
    end
  endtask

  task automatic test_simultaneous;
    int k;
    bus_a.address = 3'd2;
    bus_a.in      = 16'hAAAA;
    bus_a.load    = 1'b1;
    bus_a.clear   = 1'b1;
    tick();
    bus_a.load  = 1'b0;
    bus_a.clear = 1'b0;
    bus_a.in    = 16'h0000;
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_beats_load_busy: got %b expected 1", bus_a.busy);
    end
    k = 0;
    while (bus_a.busy === 1'b1 && k < 50) begin
      bus_a.clear = (k == 3);
      tick();
      k++;
    end
    bus_a.clear = 1'b0;
    #1;
    checks++;
    if (k !== 8) begin
      errors++;
      $display("[TB] FAIL clear_not_extended: got %0d expected 8", k);
    end
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL dropped_load_addr2: got %h expected 0000", bus_a.out);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int edges;
    bus_a.address = 3'd7;
    bus_a.in      = 16'h5555;
    bus_a.load    = 1'b1;
    tick();
    bus_a.load = 1'b0;
    bus_a.in   = 16'h0000;
    checks++;
    if (bus_a.out !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL preload_addr7: got %h expected 5555", bus_a.out);
    end
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    wait_idle(1'b0, edges);
    checks++;
    if (edges !== 8) begin
      errors++;
      $display("[TB] FAIL mid_sweep_reset_len: got %0d expected 8 (13 total)", edges);
    end
    #1;
    checks++;
    if (bus_a.out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_sweep_addr7: got %h expected 0000", bus_a.out);
    end
  endtask

  task automatic test_param_corner;
    int edges;
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    wait_idle(1'b1, edges);
    checks++;
    if (edges !== 32) begin
      errors++;
      $display("[TB] FAIL corner_sweep_len: got %0d expected 32", edges);
    end
    bus_b.address = 5'd31;
    bus_b.in      = 8'hA5;
    bus_b.load    = 1'b1;
    tick();
    bus_b.address = 5'd0;
    bus_b.in      = 8'h5A;
    tick();
    bus_b.load    = 1'b0;
    bus_b.in      = 8'h00;
    bus_b.address = 5'd31;
    #1;
    checks++;
    if (bus_b.out !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL corner_addr31: got %h expected a5", bus_b.out);
    end
    bus_b.address = 5'd0;
    #1;
    checks++;
    if (bus_b.out !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL corner_addr0: got %h expected 5a", bus_b.out);
    end
    bus_b.address = 5'd30;
    #1;
    checks++;
    if (bus_b.out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL corner_addr30: got %h expected 00", bus_b.out);
    end
  endtask

  initial begin
    clk           = 1'b0;
    errors        = 0;
    checks        = 0;
    reset_a       = 1'b0;
    reset_b       = 1'b0;
    bus_a.in      = '0;
    bus_a.address = '0;
    bus_a.load    = 1'b0;
    bus_a.clear   = 1'b0;
    bus_b.in      = '0;
    bus_b.address = '0;
    bus_b.load    = 1'b0;
    bus_b.clear   = 1'b0;
    $display("[TB] starting ramn directed tests");
    test_reset();
    test_write_read();
    test_ignored_writes();
    test_simultaneous();
    test_reset_mid_sweep();
    test_param_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
